// File: rtl/l1c_mem_arbiter.sv
// Arbitrates the single master-FSM request port between the L1 I-cache refill path and the L1 D-cache path.
// Optional build macro STARVE_GUARD_EN: bounds how long IC can be starved by back-to-back DC grants.
module l1c_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic                ic_gnt,
  output logic                ic_rvalid,
  output logic                ic_rlast,
  input  logic                dc_req,
  input  logic                dc_we,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wstrb,
  output logic                dc_gnt,
  output logic                dc_rvalid,
  output logic                dc_rlast,
  output logic                dc_wdone,
  output logic [DATA_W-1:0]   rdata,
  output logic                ARvalid,
  output logic [ADDR_W-1:0]   read_addr,
  output logic                AWvalid,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic [DATA_W/8-1:0] write_bweb,
  input  logic                read_data_valid,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                Rlast,
  input  logic                write_done
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BCNT_W = $clog2(BURST_LEN + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_IC = 2'd1;
  localparam logic [1:0] S_RD_DC = 2'd2;
  localparam logic [1:0] S_WR_DC = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  logic              ic_prio_c;

  // Grants and beat routing are zero-latency; issue registers load on the grant cycle
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    ic_gnt     = 1'b0;
    ic_rvalid  = 1'b0;
    ic_rlast   = 1'b0;
    dc_gnt     = 1'b0;
    dc_rvalid  = 1'b0;
    dc_rlast   = 1'b0;
    dc_wdone   = 1'b0;
    rdata      = '0;
    ARvalid    = 1'b0;
    AWvalid    = 1'b0;
    if (rst) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
      rd_addr_d  = '0;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      wr_strb_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          beat_cnt_d = '0;
          if (dc_req && !(ic_req && ic_prio_c)) begin
            dc_gnt = 1'b1;
            if (dc_we) begin
              AWvalid   = 1'b1;
              wr_addr_d = dc_addr;
              wr_data_d = dc_wdata;
              wr_strb_d = dc_wstrb;
              state_d   = S_WR_DC;
            end else begin
              ARvalid   = 1'b1;
              rd_addr_d = dc_addr;
              state_d   = S_RD_DC;
            end
          end else if (ic_req) begin
            ic_gnt    = 1'b1;
            ARvalid   = 1'b1;
            rd_addr_d = ic_addr;
            state_d   = S_RD_IC;
          end
        end
        S_RD_IC, S_RD_DC: begin
          rdata = read_data;
          if (state_q == S_RD_IC) begin
            ic_rvalid = read_data_valid;
            ic_rlast  = read_data_valid & Rlast;
          end else begin
            dc_rvalid = read_data_valid;
            dc_rlast  = read_data_valid & Rlast;
          end
          if (read_data_valid) begin
            beat_cnt_d = beat_cnt_q + BCNT_W'(1);
            if (Rlast) state_d = S_IDLE;
          end
        end
        S_WR_DC: begin
          dc_wdone = write_done;
          if (write_done) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign read_addr  = rd_addr_d;
  assign write_addr = wr_addr_d;
  assign write_data = wr_data_d;
  assign write_bweb = wr_strb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int unsigned SCNT_W = $clog2(STARVE_MAX + 1);

  logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign ic_prio_c = (starve_cnt_q >= SCNT_W'(STARVE_MAX));

  // Saturating count of DC grants taken while IC was waiting
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (rst || ic_gnt) begin
      starve_cnt_d = '0;
    end else if (dc_gnt && ic_req && !ic_prio_c) begin
      starve_cnt_d = starve_cnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign ic_prio_c = 1'b0;
`endif

`ifndef SYNTHESIS
  ap_params: assert property (@(posedge clk) (BURST_LEN > 0) && (STARVE_MAX > 0));

  ap_stray_beat: assert property (@(posedge clk) disable iff (rst)
    !(read_data_valid && ((state_q == S_IDLE) || (state_q == S_WR_DC))));

  ap_stray_wdone: assert property (@(posedge clk) disable iff (rst)
    !(write_done && (state_q != S_WR_DC)));

  ap_burst_len: assert property (@(posedge clk) disable iff (rst)
    !(read_data_valid && ((state_q == S_RD_IC) || (state_q == S_RD_DC)) &&
      (beat_cnt_q >= BCNT_W'(BURST_LEN))));
`endif

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Directed, table-driven bench for l1c_mem_arbiter; expectation for the starvation case follows STARVE_GUARD_EN.
module tb_l1c_mem_arbiter;

  localparam logic [8:0] F_ICG = 9'b100000000;
  localparam logic [8:0] F_DCG = 9'b010000000;
  localparam logic [8:0] F_AR  = 9'b001000000;
  localparam logic [8:0] F_AW  = 9'b000100000;
  localparam logic [8:0] F_ICV = 9'b000010000;
  localparam logic [8:0] F_ICL = 9'b000001000;
  localparam logic [8:0] F_DCV = 9'b000000100;
  localparam logic [8:0] F_DCL = 9'b000000010;
  localparam logic [8:0] F_WD  = 9'b000000001;

  localparam logic [31:0] WDATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  WSTRB = 4'h3;
  localparam logic [31:0] IC_A  = 32'h0000_1000;

  typedef struct {
    logic        rst;
    logic        icr;
    logic        dcr;
    logic        we;
    logic        rdv;
    logic        rl;
    logic        wd;
    logic [31:0] dcaddr;
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic [8:0]  flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt, ic_rvalid, ic_rlast;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_gnt, dc_rvalid, dc_rlast, dc_wdone;
  logic [31:0] rdata;
  logic        ARvalid, AWvalid;
  logic [31:0] read_addr, write_addr, write_data;
  logic [3:0]  write_bweb;
  logic        read_data_valid, Rlast, write_done;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1c_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
    .dc_rlast(dc_rlast), .dc_wdone(dc_wdone), .rdata(rdata),
    .ARvalid(ARvalid), .read_addr(read_addr), .AWvalid(AWvalid),
    .write_addr(write_addr), .write_data(write_data), .write_bweb(write_bweb),
    .read_data_valid(read_data_valid), .read_data(read_data),
    .Rlast(Rlast), .write_done(write_done)
  );

  function automatic vec_t mk(input logic r, input logic icr, input logic dcr,
                              input logic we, input logic rdv, input logic rl,
                              input logic wd, input logic [31:0] dcaddr,
                              input logic [31:0] rd, input logic [31:0] exp_addr,
                              input logic [8:0] flags);
    vec_t v;
    v.rst = r; v.icr = icr; v.dcr = dcr; v.we = we; v.rdv = rdv; v.rl = rl;
    v.wd = wd; v.dcaddr = dcaddr; v.rd = rd; v.exp_addr = exp_addr; v.flags = flags;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle shortly after the rising edge, check mid-cycle
  task automatic step(input vec_t v, input string tag);
    logic [8:0] act;
    @(posedge clk);
    #1;
    rst             = v.rst;
    ic_req          = v.icr;
    dc_req          = v.dcr;
    dc_we           = v.we;
    dc_addr         = v.dcaddr;
    read_data_valid = v.rdv;
    Rlast           = v.rl;
    write_done      = v.wd;
    read_data       = v.rd;
    #3;
    act = {ic_gnt, dc_gnt, ARvalid, AWvalid, ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, dc_wdone};
    check({tag, ".flags"}, 32'(act), 32'(v.flags));
    if ((v.flags & F_AR) != 9'd0) check({tag, ".read_addr"}, read_addr, v.exp_addr);
    if ((v.flags & F_AW) != 9'd0) begin
      check({tag, ".write_addr"}, write_addr, v.exp_addr);
      check({tag, ".write_data"}, write_data, WDATA);
      check({tag, ".write_bweb"}, 32'(write_bweb), 32'(WSTRB));
    end
    if ((v.flags & (F_ICV | F_DCV)) != 9'd0) check({tag, ".rdata"}, rdata, v.rd);
    if (v.rst) begin
      check({tag, ".rst_read_addr"}, read_addr, 32'h0);
      check({tag, ".rst_write_addr"}, write_addr, 32'h0);
      check({tag, ".rst_write_data"}, write_data, 32'h0);
      check({tag, ".rst_rdata"}, rdata, 32'h0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; ic_req = 1'b0; ic_addr = IC_A; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = WDATA; dc_wstrb = WSTRB;
    read_data_valid = 1'b0; read_data = '0; Rlast = 1'b0; write_done = 1'b0;

    // Reset, then IC refill of 4 beats
    tbl.push_back(mk(1,1,1,0,0,0,0, 32'h0, 32'h0,  32'h0, 9'd0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h0, 32'h0,  32'h0, 9'd0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 32'h0, 32'h0,  IC_A,  F_ICG | F_AR));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0, 32'h0,  32'h0, 9'd0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 32'h0, 32'hA0, 32'h0, F_ICV));
    tbl.push_back(mk(0,0,0,0,1,0,0, 32'h0, 32'hA1, 32'h0, F_ICV));
    tbl.push_back(mk(0,0,0,0,1,0,0, 32'h0, 32'hA2, 32'h0, F_ICV));
    tbl.push_back(mk(0,0,0,0,1,1,0, 32'h0, 32'hA3, 32'h0, F_ICV | F_ICL));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0, 32'h0,  32'h0, 9'd0));
    // DC single-beat write
    tbl.push_back(mk(0,0,1,1,0,0,0, 32'h0001_0004, 32'h0, 32'h0001_0004, F_DCG | F_AW));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 9'd0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 32'h0, 32'h0, 32'h0, F_WD));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 9'd0));
    // Simultaneous requests: DC read first, IC one cycle after DC Rlast
    tbl.push_back(mk(0,1,1,0,0,0,0, 32'h2000, 32'h0,  32'h2000, F_DCG | F_AR));
    tbl.push_back(mk(0,1,0,0,1,0,0, 32'h0,    32'hB0, 32'h0,    F_DCV));
    tbl.push_back(mk(0,1,0,0,1,0,0, 32'h0,    32'hB1, 32'h0,    F_DCV));
    tbl.push_back(mk(0,1,0,0,1,0,0, 32'h0,    32'hB2, 32'h0,    F_DCV));
    tbl.push_back(mk(0,1,0,0,1,1,0, 32'h0,    32'hB3, 32'h0,    F_DCV | F_DCL));
    tbl.push_back(mk(0,1,0,0,0,0,0, 32'h0,    32'h0,  IC_A,     F_ICG | F_AR));
    tbl.push_back(mk(0,0,0,0,1,0,0, 32'h0,    32'hC0, 32'h0,    F_ICV));
    tbl.push_back(mk(0,0,0,0,1,0,0, 32'h0,    32'hC1, 32'h0,    F_ICV));
    tbl.push_back(mk(0,0,0,0,1,0,0, 32'h0,    32'hC2, 32'h0,    F_ICV));
    tbl.push_back(mk(0,0,0,0,1,1,0, 32'h0,    32'hC3, 32'h0,    F_ICV | F_ICL));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0,    32'h0,  32'h0,    9'd0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of an IC refill, then a fresh DC read
    step(mk(0,1,0,0,0,0,0, 32'h0, 32'h0,  IC_A,  F_ICG | F_AR), "mrst.gnt");
    step(mk(0,0,0,0,1,0,0, 32'h0, 32'hD0, 32'h0, F_ICV), "mrst.b0");
    step(mk(0,0,0,0,1,0,0, 32'h0, 32'hD1, 32'h0, F_ICV), "mrst.b1");
    step(mk(1,0,0,0,0,0,0, 32'h0, 32'h0,  32'h0, 9'd0),  "mrst.rst");
    step(mk(0,0,0,0,0,0,0, 32'h0, 32'h0,  32'h0, 9'd0),  "mrst.idle");
    check("mrst.read_addr_cleared", read_addr, 32'h0);
    step(mk(0,0,1,0,0,0,0, 32'h3000, 32'h0,  32'h3000, F_DCG | F_AR), "mrst.dcgnt");
    for (int b = 0; b < 4; b++)
      step(mk(0,0,0,0,1,(b == 3),0, 32'h0, 32'hE0 + 32'(b), 32'h0,
              (b == 3) ? (F_DCV | F_DCL) : F_DCV), $sformatf("mrst.e%0d", b));

    // Both requesters held: DC writes back-to-back against a waiting IC
    for (int i = 0; i < 10; i++) begin
`ifdef STARVE_GUARD_EN
      if (i == 8) begin
        step(mk(0,1,1,1,0,0,0, 32'h4000, 32'h0, IC_A, F_ICG | F_AR), "starve.icgnt");
        for (int b = 0; b < 4; b++)
          step(mk(0,0,1,1,1,(b == 3),0, 32'h4000, 32'hF0 + 32'(b), 32'h0,
                  (b == 3) ? (F_ICV | F_ICL) : F_ICV), $sformatf("starve.f%0d", b));
        step(mk(0,1,1,1,0,0,0, 32'h4100, 32'h0, 32'h4100, F_DCG | F_AW), "starve.dc_after");
        step(mk(0,1,1,1,0,0,1, 32'h4100, 32'h0, 32'h0, F_WD), "starve.wd_after");
        break;
      end
`endif
      step(mk(0,1,1,1,0,0,0, 32'h4000 + 32'(i * 4), 32'h0, 32'h4000 + 32'(i * 4),
              F_DCG | F_AW), $sformatf("starve.dc%0d", i));
      step(mk(0,1,1,1,0,0,1, 32'h0, 32'h0, 32'h0, F_WD), $sformatf("starve.wd%0d", i));
    end
    step(mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 9'd0), "final.idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
